// File: rtl/vx_fpu_ncomp_mp.sv
// vx_fpu_ncomp_mp -- multi-precision non-computational FP unit
//   (FSGNJ/FSGNJN/FSGNJX, FCLASS, FMV, FMIN/FMAX, FLE/FLT/FEQ) over NUM_LANES lanes.
//   Single-precision operands held in 64-bit registers must be NaN-boxed, otherwise
//   they read as the canonical qNaN. Classification and ordering are computed before
//   the first stage; the per-op result mux sits on the last stage.
// Optional feature macro: VX_FPU_NCOMP_SKID_EN adds a 2-entry output skid buffer.
//   With it, ready_in is a flop and the latency becomes LATENCY+1.
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   valid_in/ready_in    request handshake; tag_in is carried to tag_out
//   op_type, frm, fmt    op group (INST_FPU_CMP = compare), sub-op, 0=single 1=double
//   lane_mask            active lanes; inactive lanes return result 0 and no flags
//   dataa, datab         NUM_LANES x FLEN operands
//   result, fflags       NUM_LANES x FLEN results, NUM_LANES x FP_FLAGS_BITS (NV only)
//   has_fflags           set for MIN/MAX and compares
//   valid_out/ready_out  response handshake
module vx_fpu_ncomp_mp #(
  parameter int NUM_LANES     = 1,
  parameter int TAGW          = 1,
  parameter int FLEN          = 64,
  parameter int LATENCY       = 2,
  parameter int INST_FPU_BITS = 4,
  parameter int INST_FPU_CMP  = 12,
  parameter int INST_FRM_BITS = 3,
  parameter int FP_FLAGS_BITS = 5
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               valid_in,
  output logic                               ready_in,
  input  logic [TAGW-1:0]                    tag_in,
  input  logic [INST_FPU_BITS-1:0]           op_type,
  input  logic [INST_FRM_BITS-1:0]           frm,
  input  logic                               fmt,
  input  logic [NUM_LANES-1:0]               lane_mask,
  input  logic [NUM_LANES*FLEN-1:0]          dataa,
  input  logic [NUM_LANES*FLEN-1:0]          datab,
  output logic [NUM_LANES*FLEN-1:0]          result,
  output logic                               has_fflags,
  output logic [NUM_LANES*FP_FLAGS_BITS-1:0] fflags,
  output logic [TAGW-1:0]                    tag_out,
  output logic                               valid_out,
  input  logic                               ready_out
);

  typedef struct packed {
    logic [63:0] a;       // raw operand (FMV needs the unboxed bits)
    logic [63:0] b;
    logic [9:0]  a_cls;
    logic [1:0]  b_nan;   // {qNaN, sNaN}
    logic        lt;      // total order, -0 < +0
    logic        eq;      // ordered equality, +0 == -0
  } lane_t;

  typedef struct packed {
    logic [3:0]           mod;
    logic                 fmt;
    logic [NUM_LANES-1:0] mask;
    logic [TAGW-1:0]      tag;
  } ctl_t;

  function automatic logic [63:0] widen(input logic [FLEN-1:0] x);
    logic [63:0] w;
    w = '0;
    w[FLEN-1:0] = x;
    return w;
  endfunction

  // Single values without a valid NaN box collapse to the canonical qNaN.
  function automatic logic [63:0] canon(input logic [63:0] x, input logic dbl);
    if (!dbl && FLEN == 64 && !(&x[63:32])) return 64'hFFFF_FFFF_7FC0_0000;
    return x;
  endfunction

  function automatic logic [9:0] classify(input logic [63:0] v, input logic dbl);
    logic sign, e_one, e_zero, m_zero, quiet, inf, nan, zero, sub, norm;
    sign   = dbl ? v[63] : v[31];
    e_one  = dbl ? (&v[62:52]) : (&v[30:23]);
    e_zero = dbl ? ~(|v[62:52]) : ~(|v[30:23]);
    m_zero = dbl ? ~(|v[51:0]) : ~(|v[22:0]);
    quiet  = dbl ? v[51] : v[22];
    inf  = e_one & m_zero;
    nan  = e_one & ~m_zero;
    zero = e_zero & m_zero;
    sub  = e_zero & ~m_zero;
    norm = ~e_one & ~e_zero;
    return {nan & quiet, nan & ~quiet, ~sign & inf, ~sign & norm, ~sign & sub,
            ~sign & zero, sign & zero, sign & sub, sign & norm, sign & inf};
  endfunction

  // Sign-magnitude ordering; opposite-signed zeros order as -0 < +0.
  function automatic logic lt_total(input logic [63:0] a, input logic [63:0] b, input logic dbl);
    logic sa, sb;
    logic [62:0] ma, mb;
    sa = dbl ? a[63] : a[31];
    sb = dbl ? b[63] : b[31];
    ma = dbl ? a[62:0] : {32'd0, a[30:0]};
    mb = dbl ? b[62:0] : {32'd0, b[30:0]};
    if (sa != sb) return sa;
    return sa ? (ma > mb) : (ma < mb);
  endfunction

  logic                 stall;
  logic                 advance;
  ctl_t                 pre_ctl;
  lane_t [NUM_LANES-1:0] pre_lanes;

  assign pre_ctl = '{mod:  {op_type == INST_FPU_BITS'(INST_FPU_CMP), frm[2:0]},
                     fmt:  fmt, mask: lane_mask, tag: tag_in};

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_pre
    logic [63:0] a_w, b_w, a_c, b_c;
    logic [9:0]  a_cls, b_cls;
    logic        same;
    assign a_w   = widen(dataa[gi*FLEN +: FLEN]);
    assign b_w   = widen(datab[gi*FLEN +: FLEN]);
    assign a_c   = canon(a_w, fmt);
    assign b_c   = canon(b_w, fmt);
    assign a_cls = classify(a_c, fmt);
    assign b_cls = classify(b_c, fmt);
    assign same  = fmt ? (a_c == b_c) : (a_c[31:0] == b_c[31:0]);
    assign pre_lanes[gi] = '{a: a_w, b: b_w, a_cls: a_cls, b_nan: b_cls[9:8],
                             lt: lt_total(a_c, b_c, fmt),
                             eq: same | ((|a_cls[4:3]) & (|b_cls[4:3]))};
  end

  logic [LATENCY-1:0]    st_valid;
  ctl_t                  st_ctl   [LATENCY];
  lane_t [NUM_LANES-1:0] st_lanes [LATENCY];

  assign advance = ~stall;

  // Bubbles are kept in place: every stage shifts or freezes together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_valid <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        st_ctl[i]   <= '0;
        st_lanes[i] <= '0;
      end
    end else if (advance) begin
      st_valid[0] <= valid_in;
      st_ctl[0]   <= pre_ctl;
      st_lanes[0] <= pre_lanes;
      for (int i = 1; i < LATENCY; i++) begin
        st_valid[i] <= st_valid[i-1];
        st_ctl[i]   <= st_ctl[i-1];
        st_lanes[i] <= st_lanes[i-1];
      end
    end
  end

  ctl_t                               last_ctl;
  logic                               last_has;
  logic [NUM_LANES*FLEN-1:0]          lane_res;
  logic [NUM_LANES*FP_FLAGS_BITS-1:0] lane_ff;

  assign last_ctl = st_ctl[LATENCY-1];
  assign last_has = last_ctl.mod[3] | (&last_ctl.mod[2:1]);

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_out
    lane_t       l;
    logic [63:0] r, a_c, b_c;
    logic        nv, dbl, sa, sb, sgn, a_nan, b_nan, any_nan, any_snan;
    always_comb begin
      l        = st_lanes[LATENCY-1][gi];
      dbl      = last_ctl.fmt;
      a_c      = canon(l.a, dbl);
      b_c      = canon(l.b, dbl);
      sa       = dbl ? a_c[63] : a_c[31];
      sb       = dbl ? b_c[63] : b_c[31];
      a_nan    = |l.a_cls[9:8];
      b_nan    = |l.b_nan;
      any_nan  = a_nan | b_nan;
      any_snan = l.a_cls[8] | l.b_nan[0];
      r        = '0;
      nv       = 1'b0;
      sgn      = 1'b0;
      if (last_ctl.mod[3]) begin
        case (last_ctl.mod[2:0])
          3'd0: begin nv = any_nan;  r[0] = (l.lt | l.eq) & ~any_nan; end
          3'd1: begin nv = any_nan;  r[0] = l.lt & ~l.eq & ~any_nan;  end
          3'd2: begin nv = any_snan; r[0] = l.eq & ~any_nan;          end
          default: ;
        endcase
      end else begin
        case (last_ctl.mod[2:0])
          3'd0, 3'd1, 3'd2: begin
            sgn = (last_ctl.mod[2:0] == 3'd0) ? sb :
                  (last_ctl.mod[2:0] == 3'd1) ? ~sb : (sa ^ sb);
            r = dbl ? {sgn, a_c[62:0]} : {32'hFFFF_FFFF, sgn, a_c[30:0]};
          end
          3'd3:       r = {54'd0, l.a_cls};
          3'd4, 3'd5: r = dbl ? l.a : {{32{l.a[31]}}, l.a[31:0]};
          default: begin
            // MIN (frm 6) takes a when a<b; MAX (frm 7) inverts the choice.
            nv = any_snan;
            if (a_nan && b_nan) r = dbl ? 64'h7FF8_0000_0000_0000 : 64'hFFFF_FFFF_7FC0_0000;
            else if (a_nan)     r = b_c;
            else if (b_nan)     r = a_c;
            else                r = (l.lt ^ last_ctl.mod[0]) ? a_c : b_c;
          end
        endcase
      end
      if (!last_ctl.mask[gi]) begin
        r  = '0;
        nv = 1'b0;
      end
    end
    assign lane_res[gi*FLEN +: FLEN]                   = r[FLEN-1:0];
    assign lane_ff[gi*FP_FLAGS_BITS +: FP_FLAGS_BITS] = {nv, {(FP_FLAGS_BITS-1){1'b0}}};
  end

`ifdef VX_FPU_NCOMP_SKID_EN
  localparam int OW = NUM_LANES*FLEN + NUM_LANES*FP_FLAGS_BITS + 1 + TAGW;
  logic [OW-1:0] skid_mem [2];
  logic [1:0]    skid_count, skid_count_next;
  logic          wr_ptr, rd_ptr, ready_reg, push, pop, out_has;

  // Pipeline only freezes when both entries are occupied.
  assign stall = (skid_count == 2'd2);
  assign push  = st_valid[LATENCY-1] & ~stall;
  assign pop   = (skid_count != 2'd0) & ready_out;
  assign skid_count_next = skid_count + {1'b0, push} - {1'b0, pop};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skid_mem[0] <= '0;
      skid_mem[1] <= '0;
      skid_count  <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      ready_reg   <= 1'b1;
    end else begin
      if (push) begin
        skid_mem[wr_ptr] <= {lane_res, lane_ff, last_has, last_ctl.tag};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      skid_count <= skid_count_next;
      ready_reg  <= (skid_count_next != 2'd2);
    end
  end

  assign valid_out = (skid_count != 2'd0);
  assign {result, fflags, out_has, tag_out} = skid_mem[rd_ptr];
  assign has_fflags = out_has & valid_out;
  assign ready_in   = ready_reg;
`else
  assign stall      = valid_out & ~ready_out;
  assign valid_out  = st_valid[LATENCY-1];
  assign result     = lane_res;
  assign fflags     = lane_ff;
  assign tag_out    = last_ctl.tag;
  assign has_fflags = valid_out & last_has;
  assign ready_in   = ~stall;
`endif

endmodule

// File: tb/tb_vx_fpu_ncomp_mp.sv
// Testbench for vx_fpu_ncomp_mp: directed vector table, scoreboard queue of expected
// responses pushed on input handshake and popped on output handshake.
module tb_vx_fpu_ncomp_mp;
  localparam int NL  = 2;
  localparam int TW  = 5;
  localparam int FL  = 64;
  localparam int LAT = 2;
`ifdef VX_FPU_NCOMP_SKID_EN
  localparam int EXP_LAT = LAT + 1;
`else
  localparam int EXP_LAT = LAT;
`endif
  localparam logic [3:0] OP_CMP = 4'd12;
  localparam logic [3:0] OP_NC  = 4'd0;

  logic clk, reset_n, valid_in, ready_in, fmt, has_fflags, valid_out, ready_out;
  logic [TW-1:0]    tag_in, tag_out;
  logic [3:0]       op_type;
  logic [2:0]       frm;
  logic [NL-1:0]    lane_mask;
  logic [NL*FL-1:0] dataa, datab, result;
  logic [NL*5-1:0]  fflags;

  vx_fpu_ncomp_mp #(.NUM_LANES(NL), .TAGW(TW), .FLEN(FL), .LATENCY(LAT),
                    .INST_FPU_BITS(4), .INST_FPU_CMP(12), .INST_FRM_BITS(3),
                    .FP_FLAGS_BITS(5)) dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .ready_in(ready_in),
    .tag_in(tag_in), .op_type(op_type), .frm(frm), .fmt(fmt), .lane_mask(lane_mask),
    .dataa(dataa), .datab(datab), .result(result), .has_fflags(has_fflags),
    .fflags(fflags), .tag_out(tag_out), .valid_out(valid_out), .ready_out(ready_out));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  frm;
    logic        fmt;
    logic [1:0]  mask;
    logic [63:0] a0, b0, a1, b1, r0, r1;
    logic [1:0]  nv;
    logic        has;
  } vec_t;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [127:0]  res;
    logic [9:0]    ff;
    logic          has;
    logic [31:0]   cyc;
  } sb_t;

  vec_t vecs [16];
  sb_t  sb_q [$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_total = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [2:0] f, input logic fm,
                              input logic [1:0] m, input logic [63:0] a0, input logic [63:0] b0,
                              input logic [63:0] a1, input logic [63:0] b1,
                              input logic [63:0] r0, input logic [63:0] r1,
                              input logic [1:0] nv, input logic has);
    vec_t v;
    v.op = op; v.frm = f; v.fmt = fm; v.mask = m;
    v.a0 = a0; v.b0 = b0; v.a1 = a1; v.b1 = b1;
    v.r0 = r0; v.r1 = r1; v.nv = nv; v.has = has;
    return v;
  endfunction

  task automatic drive_vec(input int idx, input int tag);
    valid_in  = 1'b1;
    tag_in    = TW'(tag);
    op_type   = vecs[idx].op;
    frm       = vecs[idx].frm;
    fmt       = vecs[idx].fmt;
    lane_mask = vecs[idx].mask;
    dataa     = {vecs[idx].a1, vecs[idx].a0};
    datab     = {vecs[idx].b1, vecs[idx].b0};
  endtask

  // One iteration per clock: inputs change on the falling edge, handshakes are
  // evaluated 1 time unit later and take effect on the next rising edge.
  task automatic run_stream(input int first, input int count, input int tag_base,
                            input int stall_at, input int stall_len, input bit lat_chk);
    int  sent = 0;
    int  recv = 0;
    int  cyc  = 0;
    sb_t item;
    vec_t v;
    logic r_before;
    while ((sent < count || sb_q.size() != 0) && cyc < 200) begin
      @(negedge clk);
      r_before  = ready_in;
      ready_out = !(cyc >= stall_at && cyc < stall_at + stall_len);
      if (sent < count) drive_vec(first + sent, tag_base + sent);
      else valid_in = 1'b0;
      #1;
`ifdef VX_FPU_NCOMP_SKID_EN
      check("ready_in_edge_only", ready_in, r_before);
`endif
      if (valid_out && ready_out) begin
        if (sb_q.size() == 0) check("unexpected_output", 1, 0);
        else begin
          item = sb_q.pop_front();
          check("tag", tag_out, item.tag);
          check("result", result, item.res);
          check("fflags", fflags, item.ff);
          check("has_fflags", has_fflags, item.has);
          if (lat_chk) check("latency", cyc_total - item.cyc, EXP_LAT);
          recv++;
          $display("out tag=%0d result=%h fflags=%h has=%0d", tag_out, result, fflags, has_fflags);
        end
      end
      if (valid_in && ready_in) begin
        v = vecs[first + sent];
        item.tag = tag_in;
        item.res = {v.r1, v.r0};
        item.ff  = {v.nv[1], 4'b0, v.nv[0], 4'b0};
        item.has = v.has;
        item.cyc = cyc_total;
        sb_q.push_back(item);
        sent++;
      end
      cyc_total++;
      cyc++;
    end
    check("stream_complete", (sent == count) && (sb_q.size() == 0), 1);
    check("received_count", recv, count);
  endtask

  localparam logic [63:0] ONE_S = 64'hFFFFFFFF_3F800000;
  localparam logic [63:0] M2_S  = 64'hFFFFFFFF_C0000000;
  localparam logic [63:0] NZ_S  = 64'hFFFFFFFF_80000000;
  localparam logic [63:0] PZ_S  = 64'hFFFFFFFF_00000000;
  localparam logic [63:0] SNAN_D = 64'h7FF0000000000001;
  localparam logic [63:0] QNAN_D = 64'h7FF8000000000000;

  initial begin
    // FMIN single
    vecs[0]  = mk(OP_NC, 3'd6, 0, 2'b11, ONE_S, M2_S, M2_S, ONE_S, M2_S, M2_S, 2'b00, 1);
    // FEQ single, lane0 bad NaN box
    vecs[1]  = mk(OP_CMP, 3'd2, 0, 2'b11, 64'h00000000_3F800000, ONE_S, ONE_S, ONE_S, 0, 1, 2'b00, 1);
    // FMAX double, sNaN and signed zeros
    vecs[2]  = mk(OP_NC, 3'd7, 1, 2'b11, SNAN_D, 64'h4000000000000000, 64'h8000000000000000, 0,
                  64'h4000000000000000, 0, 2'b01, 1);
    // FCLASS double, lane1 masked
    vecs[3]  = mk(OP_NC, 3'd3, 1, 2'b01, 64'h8000000000000000, 0, 64'h3FF0000000000000, 0, 64'h8, 0, 2'b00, 0);
    // FCLASS double -inf / qNaN
    vecs[4]  = mk(OP_NC, 3'd3, 1, 2'b11, 64'hFFF0000000000000, 0, QNAN_D, 0, 64'h1, 64'h200, 2'b00, 0);
    // FCLASS single +subnormal / sNaN
    vecs[5]  = mk(OP_NC, 3'd3, 0, 2'b11, 64'hFFFFFFFF_00000001, 0, 64'hFFFFFFFF_7F800001, 0, 64'h20, 64'h100, 2'b00, 0);
    // FSGNJN single
    vecs[6]  = mk(OP_NC, 3'd1, 0, 2'b11, ONE_S, ONE_S, M2_S, M2_S, 64'hFFFFFFFF_BF800000, 64'hFFFFFFFF_40000000, 2'b00, 0);
    // FSGNJX double
    vecs[7]  = mk(OP_NC, 3'd2, 1, 2'b11, 64'hBFF0000000000000, 64'hC000000000000000,
                  64'h3FF0000000000000, 64'hC000000000000000, 64'h3FF0000000000000, 64'hBFF0000000000000, 2'b00, 0);
    // FMV single, sign extension of raw low word
    vecs[8]  = mk(OP_NC, 3'd4, 0, 2'b11, 64'h00000000_80000001, 0, 64'h12345678_12345678, 0,
                  64'hFFFFFFFF_80000001, 64'h00000000_12345678, 2'b00, 0);
    // FLT double, lane1 qNaN signals NV
    vecs[9]  = mk(OP_CMP, 3'd1, 1, 2'b11, 64'hBFF0000000000000, 64'h3FF0000000000000, QNAN_D, 0, 1, 0, 2'b10, 1);
    // FLE single, -0 <= +0, 2.0 <= 1.0
    vecs[10] = mk(OP_CMP, 3'd0, 0, 2'b11, NZ_S, PZ_S, 64'hFFFFFFFF_40000000, ONE_S, 1, 0, 2'b00, 1);
    // FLT single, -0 < +0 false, -2 < -1 true
    vecs[11] = mk(OP_CMP, 3'd1, 0, 2'b11, NZ_S, PZ_S, M2_S, 64'hFFFFFFFF_BF800000, 0, 1, 2'b00, 1);
    // FMIN single, both NaN (one via bad box) / -0 vs +0
    vecs[12] = mk(OP_NC, 3'd6, 0, 2'b11, 0, 64'hFFFFFFFF_7FC00000, NZ_S, PZ_S,
                  64'hFFFFFFFF_7FC00000, NZ_S, 2'b00, 1);
    // FEQ double, sNaN / +0 == -0
    vecs[13] = mk(OP_CMP, 3'd2, 1, 2'b11, SNAN_D, SNAN_D, 0, 64'h8000000000000000, 0, 1, 2'b01, 1);
    // compare with frm=3: zero result, no flags
    vecs[14] = mk(OP_CMP, 3'd3, 1, 2'b11, SNAN_D, 0, 64'h3FF0000000000000, 64'h3FF0000000000000, 0, 0, 2'b00, 1);
    // FMIN double, qNaN vs -2 / sNaN vs qNaN
    vecs[15] = mk(OP_NC, 3'd6, 1, 2'b11, QNAN_D, 64'hC000000000000000, SNAN_D, QNAN_D,
                  64'hC000000000000000, QNAN_D, 2'b10, 1);

    reset_n = 1'b0; valid_in = 1'b0; ready_out = 1'b1; tag_in = '0; op_type = '0;
    frm = '0; fmt = 1'b0; lane_mask = '0; dataa = '0; datab = '0;
    #12;
    check("reset_valid_out", valid_out, 0);
    check("reset_ready_in", ready_in, 1);
    check("reset_has_fflags", has_fflags, 0);
    check("reset_result", result, 0);
    check("reset_fflags", fflags, 0);
    check("reset_tag_out", tag_out, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Full table back to back, no back-pressure: latency checked per request.
    run_stream(0, 16, 0, 0, 0, 1'b1);
    // 8 requests with ready_out low for 3 cycles mid-stream.
    run_stream(0, 8, 16, 3, 3, 1'b0);

    // Reset with two requests in flight.
    @(negedge clk);
    ready_out = 1'b1;
    drive_vec(0, 1);
    #1 check("flush_accept0", ready_in, 1);
    @(negedge clk);
    drive_vec(1, 2);
    #1 check("flush_accept1", ready_in, 1);
    @(negedge clk);
    valid_in = 1'b0;
    #1 check("flush_inflight", valid_out, 1);
    reset_n = 1'b0;
    #1;
    check("flush_valid_out", valid_out, 0);
    check("flush_has_fflags", has_fflags, 0);
    check("flush_ready_in", ready_in, 1);
    check("flush_result", result, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1 check("post_flush_no_output", valid_out, 0);
    end
    check("post_flush_ready_in", ready_in, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/vx_fpu_ncomp_mp.md
# vx_fpu_ncomp_mp

Multi-precision, parametrised-latency non-computational FP unit: FSGNJ/FMIN/FMAX/FCMP/FCLASS/FMV over `NUM_LANES` lanes. Operates on single or double precision, selected per request, with NaN-boxing for single-precision values held in 64-bit registers. Sits in the FPU dispatch fan-out alongside the FMA/DIV/SQRT/CVT units and shares their valid/ready/tag protocol. Successor to the single-precision, fixed-two-stage non-comp unit.

## Interface
- `NUM_LANES`, 1, lanes per request
- `TAGW`, 1, tag width carried alongside data
- `FLEN`, 64, register width; legal values are 32 and 64. With `FLEN`=32, `fmt`=1 is illegal.
- `LATENCY`, 2, number of pipeline stages, 1..4
- `clk` in 1: clock
- `reset_n` in 1: asynchronous, active-low reset
- `valid_in` in 1, `ready_in` out 1: input handshake
- `tag_in` in TAGW: request tag
- `op_type` in `INST_FPU_BITS`: `INST_FPU_CMP` selects compare; all other values select the non-compare group
- `frm` in `INST_FRM_BITS`: sub-op select
- `fmt` in 1: 0 = single, 1 = double
- `lane_mask` in NUM_LANES: active lanes
- `dataa`, `datab` in NUM_LANES×FLEN: operands
- `result` out NUM_LANES×FLEN
- `has_fflags` out 1
- `fflags` out NUM_LANES×`FP_FLAGS_BITS`: only NV is ever set
- `tag_out` out TAGW
- `valid_out` out 1, `ready_out` in 1: output handshake

## Operation
**Op decode**
- `mod = {op_type==INST_FPU_CMP, frm[2:0]}`.
- Non-compare group, by `frm`:
  - 0/1/2: SGNJ / SGNJN / SGNJX
  - 3: CLASS
  - 4/5: FMV
  - 6: MIN
  - 7: MAX
- Compare group (`mod[3]`=1), by `frm`: 0 LE, 1 LT, 2 EQ. `frm` ≥ 3 gives result 0 and NV 0.

**Single precision (`fmt`=0) with `FLEN`=64**
- An operand whose bits [63:32] are not all ones is treated as canonical qNaN 0x7FC00000.
- FP results (SGNJ, MIN, MAX) are NaN-boxed: upper 32 bits all ones.
- Integer results (CMP, CLASS) are zero-extended.
- FMV returns `dataa[31:0]` sign-extended to FLEN.

**Canonical qNaN**
- Single: 0x7FC00000. Double: 0x7FF8000000000000.

**Classification**
- Per format: EXP 8/11 bits, MAN 23/52 bits.
- CLASS mask bits 0..9: −inf, −norm, −sub, −0, +0, +sub, +norm, +inf, sNaN, qNaN.

**MIN/MAX**
- Both operands NaN: canonical qNaN.
- One operand NaN: the other operand.
- Otherwise the ordered min/max. −0 is less than +0.
- NV = either operand is sNaN.

**CMP**
- LE/LT with any NaN operand: result 0, NV 1.
- EQ with any NaN operand: result 0, NV = either operand is sNaN.
- +0 == −0.

**Flags**
- SGNJ, CLASS, FMV: NV 0.
- `has_fflags` = MIN/MAX or CMP.
- Inactive lanes (`lane_mask[i]`=0): result 0, fflags 0. Mask bits are pipelined with the data.

## Timing
**Pipeline**
- `LATENCY`-deep; each stage is a valid bit plus a payload register.
- Classification and compare are computed before stage 0; op muxing happens in the last stage.
- Stall: `stall = valid_out & ~ready_out`. All stages freeze while `stall` is high.
- `ready_in = ~stall`. Without the skid buffer this is a combinational path from `ready_out`.

**Latency**
- An accepted input appears on `valid_out` exactly `LATENCY` cycles later if there is no stall.
- Throughput is one request per cycle.
- Bubbles are not collapsed: a stage holding valid=0 still freezes under stall.

**Reset (`reset_n` low, any time)**
- All valid bits clear immediately; in-flight requests are dropped.
- `valid_out`=0, `has_fflags`=0, `result`/`fflags`/`tag_out`=0.
- `ready_in`=1 after reset.

**Handshake**
- `result`, `tag_out`, `fflags` and `has_fflags` stay stable while `valid_out & ~ready_out`.
- When `valid_in` arrives during a stall it is not accepted; the requester must hold it.

## Configuration
- `VX_FPU_NCOMP_SKID_EN` defined:
  - A 2-entry output skid buffer follows the last stage. The pipeline advances whenever the buffer is not full.
  - `ready_in` is a registered flop equal to "buffer count < 2". There is no combinational path from `ready_out` to `ready_in`.
  - Latency is `LATENCY`+1.
  - On reset the buffer count is 0 and `ready_in` is 1.
  - When the buffer is full, the in-flight pipeline is frozen until `ready_out`.
- `VX_FPU_NCOMP_SKID_EN` not defined:
  - No buffer; behaviour is exactly as in Timing.

## Test plan
- **FMIN single, FLEN=64:** a=0xFFFFFFFF_3F800000 (1.0), b=0xFFFFFFFF_C0000000 (−2.0) -> result 0xFFFFFFFF_C0000000, NV 0, `has_fflags`=1, after `LATENCY` cycles.
- **Bad NaN box:** FEQ single, a=0x00000000_3F800000, b=0xFFFFFFFF_3F800000 -> result 0. a is treated as canonical qNaN, so NV 0.
- **FMAX double with sNaN:** a=0x7FF0000000000001, b=0x4000000000000000 -> result 0x4000000000000000, NV 1.
- **FCLASS double:** −0.0 (0x8000000000000000) -> result 0x8. Same request with `lane_mask`=0 on lane 1 -> lane 1 result 0.
- **Back-pressure:** stream 8 back-to-back requests, hold `ready_out` low for 3 cycles mid-stream -> all 8 tags emerge in order, none lost or duplicated. With SKID_EN, check `ready_in` changes only on `clk` edges.
- **Reset mid-flight:** assert `reset_n` low with 2 requests in flight -> `valid_out` is 0 immediately, no stale output after release, `ready_in` is 1.
